// File: rtl/lbm_fp_pkg.sv
// lbm_fp_pkg: shared status and arbiter state types for the fixed-point divide path
package lbm_fp_pkg;
  typedef enum logic [1:0] {OK, DBZ, OVF, TMO} status_t;
  typedef enum logic [2:0] {FLUSH_ISSUE, FLUSH_WAIT, IDLE, WAIT, RESP} arb_state_t;
endpackage

// File: rtl/fp_div.sv
// fp_div: bit-serial signed fixed-point divider, one quotient bit per cycle, no reset
module fp_div #(
  parameter int WIDTH = 64,
  parameter int FBITS = 56
) (
  input  logic             clk,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             dbz,
  output logic             ovf,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);
  localparam int N = WIDTH + FBITS;
  localparam int CW = $clog2(N + 1);
  logic [CW-1:0] cnt;
  logic [N-1:0] num;
  logic [WIDTH-1:0] den, rem, quo, rem_nx, quo_nx, ax, ay;
  logic [WIDTH:0] diff;
  logic neg_q, neg_r, fit, last, ovf_hit;
  assign ax = x[WIDTH-1] ? -x : x;
  assign ay = y[WIDTH-1] ? -y : y;
  assign diff = {rem, num[N-1]} - {1'b0, den};
  assign fit = !diff[WIDTH];
  assign rem_nx = fit ? diff[WIDTH-1:0] : {rem[WIDTH-2:0], num[N-1]};
  assign quo_nx = {quo[WIDTH-2:0], fit};
  assign last = cnt == CW'(N - 1);
  // after WIDTH steps every quotient bit above the signed result range is known
  assign ovf_hit = cnt == CW'(WIDTH - 1) && |quo_nx[WIDTH-1:WIDTH-1-FBITS];
  assign q = neg_q ? -quo : quo;
  assign r = neg_r ? -rem : rem;
  always_ff @(posedge clk) begin
    if (start) begin
      busy <= y != '0;
      dbz <= y == '0;
      ovf <= 1'b0;
      cnt <= '0;
      num <= {ax, {FBITS{1'b0}}};
      den <= ay;
      rem <= '0;
      quo <= '0;
      neg_q <= x[WIDTH-1] ^ y[WIDTH-1];
      neg_r <= x[WIDTH-1];
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      num <= num << 1;
      rem <= rem_nx;
      quo <= quo_nx;
      ovf <= ovf_hit;
      busy <= !(last || ovf_hit);
    end
  end
endmodule

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin sharing of one fp_div among NREQ requesters.
// Optional watchdog: define FP_DIV_ARB_TIMEOUT_EN.
module fp_div_arbiter
  import lbm_fp_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int FBITS = 56,
  parameter int NREQ = 4,
  parameter int TMO_CYC = WIDTH + FBITS + 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    x_in,
  input  logic [NREQ*WIDTH-1:0]    y_in,
  output logic [NREQ-1:0]          gnt,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_q,
  output logic [WIDTH-1:0]         rsp_r,
  output status_t                  rsp_status,
  output logic                     idle
);
  localparam int IW = $clog2(NREQ);
  arb_state_t state, state_nx;
  logic [IW-1:0] ptr, pick;
  logic found, done, tmo;
  logic div_start, div_busy, div_dbz, div_ovf;
  logic [WIDTH-1:0] div_x, div_y, div_q, div_r;
  fp_div #(.WIDTH(WIDTH), .FBITS(FBITS)) u_div (
    .clk(clk), .start(div_start), .x(div_x), .y(div_y),
    .busy(div_busy), .dbz(div_dbz), .ovf(div_ovf), .q(div_q), .r(div_r)
  );
`ifdef FP_DIV_ARB_TIMEOUT_EN
  logic [$clog2(TMO_CYC+1)-1:0] tmo_cnt;
  always_ff @(posedge clk) tmo_cnt <= (rst_n && state == WAIT) ? tmo_cnt + 1'b1 : '0;
  assign tmo = div_busy && tmo_cnt == ($clog2(TMO_CYC+1))'(TMO_CYC - 1);
`else
  assign tmo = 1'b0;
`endif
  assign found = |req;
  assign done = state == WAIT && (tmo || !div_busy);
  assign idle = state == IDLE;
  // descending scan so the nearest requester after ptr wins
  always_comb begin
    pick = ptr;
    for (int k = NREQ; k >= 1; k--)
      if (req[(int'(ptr) + k) % NREQ]) pick = IW'((int'(ptr) + k) % NREQ);
  end
  always_comb begin
    state_nx = state;
    div_start = 1'b0;
    div_x = '0;
    div_y = '0;
    gnt = '0;
    case (state)
      FLUSH_ISSUE: begin
        div_start = 1'b1;
        div_y = WIDTH'(1);
        state_nx = FLUSH_WAIT;
      end
      FLUSH_WAIT: state_nx = div_busy ? FLUSH_WAIT : IDLE;
      IDLE: if (found && rst_n) begin
        gnt[pick] = 1'b1;
        div_start = 1'b1;
        div_x = x_in[int'(pick)*WIDTH +: WIDTH];
        div_y = y_in[int'(pick)*WIDTH +: WIDTH];
        state_nx = WAIT;
      end
      WAIT: state_nx = done ? RESP : WAIT;
      RESP: if (rsp_ready) state_nx = (rsp_status == TMO) ? FLUSH_ISSUE : IDLE;
      default: state_nx = FLUSH_ISSUE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FLUSH_ISSUE;
      ptr <= '0;
      rsp_id <= '0;
      rsp_valid <= 1'b0;
      rsp_q <= '0;
      rsp_r <= '0;
      rsp_status <= OK;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        ptr <= pick;
        rsp_id <= pick;
      end
      if (done) begin
        rsp_valid <= 1'b1;
        rsp_status <= tmo ? TMO : div_dbz ? DBZ : div_ovf ? OVF : OK;
        rsp_q <= (tmo || div_dbz || div_ovf) ? '0 : div_q;
        rsp_r <= (tmo || div_dbz || div_ovf) ? '0 : div_r;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb_fp_div_arbiter: directed stimulus, per-cycle transaction model plus literal latency/result pins
module tb_fp_div_arbiter;
  localparam int W = 64;
  localparam int F = 56;
  localparam int NR = 4;
  localparam logic [63:0] ONE = 64'h0100_0000_0000_0000;
  logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR*W-1:0] x_in = '0, y_in = '0;
  logic [NR-1:0] gnt;
  logic rsp_valid, idle;
  logic [1:0] rsp_id, rsp_status;
  logic [W-1:0] rsp_q, rsp_r;
  int n_chk = 0, n_pass = 0, cyc = 0;
  int gnt_ids[$], gnt_cyc[$], rsp_cyc[$], rsp_ids[$], rsp_st[$];
  logic [63:0] rsp_qs[$];
  int hs_cyc = 0;

  fp_div_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .x_in(x_in), .y_in(y_in), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_q(rsp_q),
    .rsp_r(rsp_r), .rsp_status(rsp_status), .idle(idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
  endtask

  function automatic int rr_pick(input int p, input logic [NR-1:0] r);
    for (int k = 1; k <= NR; k++) if (r[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  // expected result straight from the arithmetic definition of a fixed-point divide
  task automatic model(input logic [63:0] x, input logic [63:0] y, output logic [63:0] q,
                       output logic [63:0] r, output logic [1:0] st, output int lat);
    logic [127:0] ax, ay, mag, rm;
    logic [63:0] mq, mr, nx, ny;
    nx = -x;
    ny = -y;
    ax = {64'b0, x[63] ? nx : x};
    ay = {64'b0, y[63] ? ny : y};
    q = '0;
    r = '0;
    if (y == 0) begin
      st = 2'd1;
      lat = 2;
    end else begin
      mag = (ax << F) / ay;
      rm = (ax << F) % ay;
      if (mag >= (128'd1 << (W - 1))) begin
        st = 2'd2;
        lat = W + 2;
      end else begin
        st = 2'd0;
        lat = W + F + 2;
        mq = mag[63:0];
        mr = rm[63:0];
        q = (x[63] ^ y[63]) ? -mq : mq;
        r = x[63] ? -mr : mr;
      end
    end
  endtask

  bit armed = 0, rchk = 0, out_n = 0, prev_valid = 0;
  int flush_until = 0, due = 0, mptr = 0, e_id = 0, e_lat = 0, p;
  logic [63:0] e_q, e_r;
  logic [1:0] e_st;
  logic [NR-1:0] e_gnt;
  always @(negedge clk) begin
    if (rchk) begin
      chk("reset_valid", 64'(rsp_valid), 0);
      chk("reset_id", 64'(rsp_id), 0);
      chk("reset_q", rsp_q, 0);
      chk("reset_r", rsp_r, 0);
      chk("reset_status", 64'(rsp_status), 0);
    end
    if (armed) begin
      chk("idle", 64'(idle), 64'(cyc >= flush_until && !out_n));
      e_gnt = '0;
      p = rr_pick(mptr, req);
      if (cyc >= flush_until && !out_n && rst_n && p >= 0) e_gnt[p] = 1'b1;
      chk("gnt", 64'(gnt), 64'(e_gnt));
      chk("rsp_valid", 64'(rsp_valid), 64'(out_n && cyc >= due));
      if (out_n && cyc >= due && rsp_valid) begin
        chk("rsp_id", 64'(rsp_id), 64'(e_id));
        chk("rsp_q", rsp_q, e_q);
        chk("rsp_r", rsp_r, e_r);
        chk("rsp_status", 64'(rsp_status), 64'(e_st));
      end
    end
    if (rsp_valid && !prev_valid) begin
      rsp_cyc.push_back(cyc);
      rsp_ids.push_back(int'(rsp_id));
      rsp_qs.push_back(rsp_q);
      rsp_st.push_back(int'(rsp_status));
    end
    prev_valid = rsp_valid;
    rchk = !rst_n;
    if (!rst_n) begin
      armed = 1;
      out_n = 0;
      mptr = 0;
      flush_until = cyc + 1 + W + F + 2;
    end else if (armed) begin
      if (out_n && rsp_valid && rsp_ready) begin
        out_n = 0;
        hs_cyc = cyc;
      end
      if (|e_gnt) begin
        out_n = 1;
        mptr = p;
        e_id = p;
        model(x_in[p*W +: W], y_in[p*W +: W], e_q, e_r, e_st, e_lat);
        due = cyc + e_lat;
        gnt_ids.push_back(p);
        gnt_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && !idle; i++) tick(1);
    chk("idle_reached", 64'(idle), 1);
  endtask

  task automatic run_one(input int idx, input logic [63:0] x, input logic [63:0] y);
    wait_idle();
    x_in[idx*W +: W] = x;
    y_in[idx*W +: W] = y;
    req = '0;
    req[idx] = 1'b1;
    tick(1);
    req = '0;
    wait_idle();
  endtask

  task automatic check_last(input string nm, input int id, input int lat,
                            input logic [63:0] q, input int st);
    if (rsp_cyc.size() == 0 || gnt_cyc.size() == 0) begin
      chk({nm, "_present"}, 0, 1);
    end else begin
      chk({nm, "_gnt_id"}, 64'(gnt_ids[$]), 64'(id));
      chk({nm, "_rsp_id"}, 64'(rsp_ids[$]), 64'(id));
      chk({nm, "_latency"}, 64'(rsp_cyc[$] - gnt_cyc[$]), 64'(lat));
      chk({nm, "_q"}, rsp_qs[$], q);
      chk({nm, "_status"}, 64'(rsp_st[$]), 64'(st));
    end
  endtask

  initial begin
    int base, n, c;
    tick(2);
    rst_n = 1'b1;
    run_one(0, 3 * ONE, 2 * ONE);
    check_last("div_pos", 0, 122, 64'h0180_0000_0000_0000, 0);
    run_one(2, 64'hFD00_0000_0000_0000, 2 * ONE);
    check_last("div_neg", 2, 122, 64'hFE80_0000_0000_0000, 0);
    run_one(1, 5 * ONE, 0);
    check_last("dbz", 1, 2, 0, 1);
    run_one(3, 64'h7F00_0000_0000_0000, 64'h0001_0000_0000_0000);
    check_last("ovf", 3, 66, 0, 2);
    wait_idle();
    for (int i = 0; i < NR; i++) begin
      x_in[i*W +: W] = 64'(i + 1) * ONE;
      y_in[i*W +: W] = (i % 2 == 0) ? 2 * ONE : 64'h0;
    end
    base = gnt_ids.size();
    req = 4'b1111;
    for (int i = 0; i < 2000 && gnt_ids.size() < base + 5; i++) tick(1);
    req = '0;
    wait_idle();
    chk("rr_all_count", 64'(gnt_ids.size() - base), 5);
    for (int i = 0; i < 5 && base + i < gnt_ids.size(); i++)
      chk("rr_all_order", 64'(gnt_ids[base + i]), 64'(i % 4));
    run_one(3, ONE, 2 * ONE);
    base = gnt_ids.size();
    req = 4'b0101;
    for (int i = 0; i < 2000 && gnt_ids.size() < base + 3; i++) tick(1);
    req = '0;
    wait_idle();
    chk("rr_sparse_count", 64'(gnt_ids.size() - base), 3);
    if (gnt_ids.size() >= base + 3) begin
      chk("rr_sparse_0", 64'(gnt_ids[base]), 0);
      chk("rr_sparse_1", 64'(gnt_ids[base + 1]), 2);
      chk("rr_sparse_2", 64'(gnt_ids[base + 2]), 0);
    end
    x_in[1*W +: W] = ONE;
    y_in[1*W +: W] = 3 * ONE;
    x_in[2*W +: W] = 64'hFF80_0000_0000_0000;
    y_in[2*W +: W] = 3 * ONE;
    rsp_ready = 1'b0;
    req = 4'b0010;
    tick(1);
    req = 4'b0100;
    for (int i = 0; i < 300 && !rsp_valid; i++) tick(1);
    chk("bp_valid", 64'(rsp_valid), 1);
    n = gnt_ids.size();
    tick(10);
    chk("bp_no_gnt", 64'(gnt_ids.size()), 64'(n));
    rsp_ready = 1'b1;
    tick(2);
    req = '0;
    chk("bp_gnt_id", 64'(gnt_ids[$]), 2);
    chk("bp_gnt_gap", 64'(gnt_cyc[$] - hs_cyc), 1);
    wait_idle();
    chk("bp_rsp_q", rsp_qs[$], 64'hFFD5_5555_5555_5556);
    run_one(0, 5 * ONE, 2 * ONE);
    x_in[0*W +: W] = 7 * ONE;
    req = 4'b0001;
    tick(1);
    req = '0;
    tick(20);
    n = rsp_cyc.size();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    c = 0;
    while (!idle && c < 400) begin
      tick(1);
      c++;
    end
    chk("flush_len", 64'(c), W + F + 2);
    chk("reset_drops_rsp", 64'(rsp_cyc.size()), 64'(n));
    run_one(1, 3 * ONE, 2 * ONE);
    check_last("after_reset", 1, 122, 64'h0180_0000_0000_0000, 0);
    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
